relm_div_seq: RTL and testbench

Multi-cycle iterative integer divider for the ReLM custom-instruction datapath. It replaces the software-driven DIVINIT/DIVLOOP sequence with a self-sequencing restoring divider that retires STEPS quotient bits per clock. It sits beside the combinational custom unit. Handshaking is start/busy/done, and `retry_out` stalls the issuing core while a division is in flight.

---
 rtl/relm_div_seq.sv | 160 ++++++++++++++++
 tb/tb_relm_div_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/relm_div_seq.sv
// relm_div_seq: self-sequencing restoring divider, STEPS quotient bits per clock, start/busy/done handshake.
// Define RELM_DIV_SIGNED_EN to honour signed_in (abs-value load stage and sign fixup); otherwise operands are unsigned.
`timescale 1ns/1ps

module relm_div_seq #(
  parameter int WD    = 32,
  parameter int STEPS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic          signed_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          done_out,
  output logic          retry_out
);

  localparam int K  = WD / STEPS;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(K - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [WD-1:0] n_reg;
  logic [WD-1:0] d_reg;
  logic [WD-1:0] r_reg;
  logic [CW-1:0] cnt;
  logic          div_zero;

  logic          d_is_zero;
  logic [WD-1:0] n_load;
  logic [WD-1:0] d_load;
  logic [WD-1:0] q_fix;
  logic [WD-1:0] r_fix;

  logic [WD-1:0] n_step;
  logic [WD-1:0] r_step;
  logic [WD:0]   rem;
  logic [WD:0]   diff;

  assign d_is_zero = (d_in == '0);
  assign retry_out = (state != IDLE);

`ifdef RELM_DIV_SIGNED_EN
  logic n_sign;
  logic d_sign;
  logic q_neg;
  logic r_neg;

  always_comb begin
    n_sign = signed_in & n_in[WD-1];
    d_sign = signed_in & d_in[WD-1];
    n_load = n_sign ? (-n_in) : n_in;
    d_load = d_sign ? (-d_in) : d_in;
    q_fix  = q_neg ? (-n_reg) : n_reg;
    r_fix  = r_neg ? (-r_reg) : r_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start_in) begin
      q_neg <= n_sign ^ d_sign;
      r_neg <= n_sign;
    end
  end
`else
  logic unused_signed_in;

  assign unused_signed_in = signed_in;

  always_comb begin
    n_load = n_in;
    d_load = d_in;
    q_fix  = n_reg;
    r_fix  = r_reg;
  end
`endif

  // Quotient bits shift into the vacated LSBs of n_reg, so n_reg ends up holding the quotient magnitude.
  always_comb begin
    n_step = n_reg;
    r_step = r_reg;
    rem    = '0;
    diff   = '0;
    for (int s = 0; s < STEPS; s++) begin
      rem    = {r_step, n_step[WD-1]};
      diff   = rem - {1'b0, d_reg};
      n_step = {n_step[WD-2:0], ~diff[WD]};
      r_step = diff[WD] ? rem[WD-1:0] : diff[WD-1:0];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_in) next_state = d_is_zero ? FIX : RUN;
      RUN:  if (cnt == '0) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Divide by zero keeps the raw dividend in n_reg so FIX can return it unmodified.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg    <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      q_out    <= '0;
      r_out    <= '0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            div_zero <= d_is_zero;
            n_reg    <= d_is_zero ? n_in : n_load;
            d_reg    <= d_load;
            r_reg    <= '0;
            cnt      <= CNT_LOAD;
          end
        end
        RUN: begin
          n_reg <= n_step;
          r_reg <= r_step;
          cnt   <= cnt - CNT_ONE;
        end
        FIX: begin
          done_out <= 1'b1;
          q_out    <= div_zero ? '1 : q_fix;
          r_out    <= div_zero ? n_reg : r_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relm_div_seq.sv
// tb_relm_div_seq: directed-vector bench for relm_div_seq (WD=32, STEPS=2), expectations computed by hand.
`timescale 1ns/1ps

module tb_relm_div_seq;

  logic        clk;
  logic        rst;
  logic        start_in;
  logic        signed_in;
  logic [31:0] n_in;
  logic [31:0] d_in;
  logic [31:0] q_out;
  logic [31:0] r_out;
  logic        done_out;
  logic        retry_out;

  int total;
  int bad;

  relm_div_seq #(.WD(32), .STEPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .signed_in (signed_in),
    .n_in      (n_in),
    .d_in      (d_in),
    .q_out     (q_out),
    .r_out     (r_out),
    .done_out  (done_out),
    .retry_out (retry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench #1 after the sampling edge, i.e. in cycle 1 of the operation.
  task automatic launch(input logic [31:0] n, input logic [31:0] d, input logic sg);
    @(negedge clk);
    n_in      = n;
    d_in      = d;
    signed_in = sg;
    start_in  = 1'b1;
    @(posedge clk);
    #1;
    start_in  = 1'b0;
  endtask

  // Advances until done_out, counting cycles and any cycle where retry_out is wrong.
  task automatic wait_done(input int cyc0, output int cyc, output int retry_bad);
    cyc       = cyc0;
    retry_bad = 0;
    while (!done_out && cyc < 100) begin
      if (retry_out !== 1'b1) retry_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (retry_out !== 1'b0) retry_bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (q_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_q got %h want %h", q_out, 32'h0); end
    total++; if (r_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_r got %h want %h", r_out, 32'h0); end
    total++; if (done_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got %b want 0", done_out); end
    total++; if (retry_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_retry got %b want 0", retry_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divide(input string name, input logic [31:0] n, input logic [31:0] d, input logic sg,
                             input logic [31:0] eq, input logic [31:0] er, input int ecyc);
    int cyc;
    int rb;
    launch(n, d, sg);
    wait_done(1, cyc, rb);
    total++; if (cyc !== ecyc) begin bad++; $display("[TB] FAIL %s latency got %0d want %0d", name, cyc, ecyc); end
    total++; if (rb !== 0) begin bad++; $display("[TB] FAIL %s retry got %0d bad cycles want 0", name, rb); end
    total++; if (q_out !== eq) begin bad++; $display("[TB] FAIL %s q got %h want %h", name, q_out, eq); end
    total++; if (r_out !== er) begin bad++; $display("[TB] FAIL %s r got %h want %h", name, r_out, er); end
    @(posedge clk);
    #1;
    total++; if (done_out !== 1'b0) begin bad++; $display("[TB] FAIL %s done_pulse got %b want 0", name, done_out); end
    total++; if (q_out !== eq) begin bad++; $display("[TB] FAIL %s q_hold got %h want %h", name, q_out, eq); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int rb;
    int rb0;
    launch(32'd100, 32'd7, 1'b0);
    cyc = 1;
    rb0 = 0;
    while (cyc < 5) begin
      if (retry_out !== 1'b1) rb0++;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_in     = 32'd9;
    d_in     = 32'd3;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    wait_done(6, cyc, rb);
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL b2b_first latency got %0d want 18", cyc); end
    total++; if (rb + rb0 !== 0) begin bad++; $display("[TB] FAIL b2b_first retry got %0d bad cycles want 0", rb + rb0); end
    total++; if (q_out !== 32'd14) begin bad++; $display("[TB] FAIL b2b_first q got %h want %h", q_out, 32'd14); end
    total++; if (r_out !== 32'd2) begin bad++; $display("[TB] FAIL b2b_first r got %h want %h", r_out, 32'd2); end
    n_in     = 32'd9;
    d_in     = 32'd3;
    start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    wait_done(1, cyc, rb);
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL b2b_second latency got %0d want 18", cyc); end
    total++; if (q_out !== 32'd3) begin bad++; $display("[TB] FAIL b2b_second q got %h want %h", q_out, 32'd3); end
    total++; if (r_out !== 32'd0) begin bad++; $display("[TB] FAIL b2b_second r got %h want %h", r_out, 32'd0); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int dones;
    launch(32'd100, 32'd7, 1'b0);
    cyc = 1;
    while (cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (q_out !== 32'h0) begin bad++; $display("[TB] FAIL abort_q got %h want %h", q_out, 32'h0); end
    total++; if (r_out !== 32'h0) begin bad++; $display("[TB] FAIL abort_r got %h want %h", r_out, 32'h0); end
    total++; if (retry_out !== 1'b0) begin bad++; $display("[TB] FAIL abort_retry got %b want 0", retry_out); end
    total++; if (done_out !== 1'b0) begin bad++; $display("[TB] FAIL abort_done got %b want 0", done_out); end
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_out) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", dones); end
    test_divide("after_abort", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 18);
  endtask

  task automatic test_reset_start;
    int dones;
    @(negedge clk);
    rst       = 1'b1;
    start_in  = 1'b1;
    n_in      = 32'd100;
    d_in      = 32'd7;
    signed_in = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    start_in = 1'b0;
    total++; if (retry_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_start_retry got %b want 0", retry_out); end
    dones = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done_out || retry_out) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("[TB] FAIL rst_start_dropped got %0d busy/done cycles want 0", dones); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start_in  = 1'b0;
    signed_in = 1'b0;
    n_in      = 32'h0;
    d_in      = 32'h0;

    test_reset();
    test_divide("basic_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 18);
    test_divide("div_zero", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 2);
    test_divide("big_unsigned", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 18);
    test_divide("d_gt_n", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 18);
    test_divide("div_zero_signed", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 2);
`ifdef RELM_DIV_SIGNED_EN
    test_divide("signed_neg_n", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 18);
    test_divide("signed_neg_d", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 18);
    test_divide("signed_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 18);
`else
    test_divide("signed_neg_n", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 18);
    test_divide("signed_neg_d", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 18);
    test_divide("signed_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 18);
`endif
    test_divide("unsigned_mode_neg", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 18);
    test_back_to_back();
    test_reset_mid();
    test_reset_start();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
